// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS integer-subset core with req/ack instruction and data memory ports.
// Optional performance counters (cycle_cnt, retire_cnt) are enabled by defining MIPS_PERF_CNT_EN.
module mips_multicycle_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              halted
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d, pc_inc;
  logic                      started_q, started_d;
  logic [DATA_W-1:0]         value_q, value_d;
  logic                      value_valid_q, value_valid_d;
  logic [DATA_W-1:0]         regs_q [NREG];

  logic [31:0]               ir_q, ir_d;
  logic signed [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]         res_q, res_d;
  logic [4:0]                dest_q, dest_d;
  logic                      store_q, store_d;

  logic signed [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]         rs_val, rt_val;
  logic [5:0]                op, funct;
  logic                      rf_we;
  logic                      retire;
  logic                      unused_shamt;

  // Register index is usable when nonzero and below NREG.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ((32'(idx) >> RIDX_W) == 32'd0);
  endfunction

  assign op           = ir_q[31:26];
  assign funct        = ir_q[5:0];
  assign imm          = DATA_W'($signed(ir_q[15:0]));
  assign pc_inc       = pc_q + 1'b1;
  assign unused_shamt = ^ir_q[10:6];

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (idx_ok(ir_q[25:21])) rs_val = regs_q[ir_q[21+RIDX_W-1:21]];
    if (idx_ok(ir_q[20:16])) rt_val = regs_q[ir_q[16+RIDX_W-1:16]];
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    started_d     = 1'b1;
    value_d       = value_q;
    value_valid_d = 1'b0;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    dest_d        = dest_q;
    store_d       = store_q;
    rf_we         = 1'b0;
    retire        = 1'b0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    case (state_q)
      S_IF: begin
        // First cycle after reset release only arms the fetch.
        if (started_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = S_ID;
          end
        end
      end
      S_ID: begin
        if (ir_q == 32'hFFFF_FFFF) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          a_d     = rs_val;
          b_d     = rt_val;
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        pc_d    = pc_inc;
        retire  = 1'b1;
        case (op)
          6'h00: begin
            dest_d  = ir_q[15:11];
            state_d = S_WB;
            pc_d    = pc_q;
            retire  = 1'b0;
            case (funct)
              6'h20:   res_d = a_q + b_q;
              6'h22:   res_d = a_q - b_q;
              6'h24:   res_d = a_q & b_q;
              6'h25:   res_d = a_q | b_q;
              6'h2A:   res_d = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
              default: begin
                state_d = S_IF;
                pc_d    = pc_inc;
                retire  = 1'b1;
              end
            endcase
          end
          6'h08: begin
            res_d   = a_q + imm;
            dest_d  = ir_q[20:16];
            state_d = S_WB;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          6'h23, 6'h2B: begin
            res_d   = a_q + imm;
            store_d = (op == 6'h2B);
            state_d = S_MEM;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          6'h04: begin
            if (a_q == b_q) pc_d = pc_inc + imm[ADDR_W-1:0];
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (store_q) begin
            pc_d    = pc_inc;
            state_d = S_IF;
            retire  = 1'b1;
          end else begin
            res_d   = dmem_rdata;
            dest_d  = ir_q[20:16];
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = idx_ok(dest_q);
        if (rf_we) begin
          value_d       = res_q;
          value_valid_d = 1'b1;
        end
        pc_d    = pc_inc;
        state_d = S_IF;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IF;
      pc_q          <= '0;
      started_q     <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      started_q     <= started_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      if (rf_we) regs_q[dest_q[RIDX_W-1:0]] <= res_q;
    end
  end

  // Datapath holding registers carry no reset; outputs that expose them are gated.
  always_ff @(posedge clk) begin
    ir_q    <= ir_d;
    a_q     <= a_d;
    b_q     <= b_d;
    res_q   <= res_d;
    dest_q  <= dest_d;
    store_q <= store_d;
  end

  assign imem_addr   = pc_q;
  assign dmem_we     = dmem_req & store_q;
  assign dmem_addr   = dmem_req ? res_q[ADDR_W-1:0] : '0;
  assign dmem_wdata  = dmem_we ? b_q : '0;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign halted      = (state_q == S_HALT);

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (state_q != S_HALT && cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (retire && retire_cnt_q != 32'hFFFF_FFFF) retire_cnt_d = retire_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: memory responders with wait states,
// expected writeback values and fetch addresses queued per program and checked by monitors.
module tb_mips_multicycle_core;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, value_valid, halted;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_rdata;
  logic [DW-1:0] dmem_wdata, dmem_rdata, value;

  mips_multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .value(value), .value_valid(value_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0]   imem [0:1023];
  logic [DW-1:0] dmem [0:1023];
  int            imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
  logic [AW-1:0] last_st_addr = '0;
  int            n_chk = 0, n_fail = 0;
  logic [DW-1:0] exp_val_q [$];
  logic [AW-1:0] exp_fetch_q [$];
  bit            fetch_chk = 1'b0;

  logic          pv_ireq = 1'b0, pv_dreq = 1'b0, pv_we = 1'b0;
  logic [AW-1:0] pv_iaddr = '0, pv_daddr = '0;
  logic [DW-1:0] pv_wdata = '0;

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  // Instruction memory responder
  always @(posedge clk) begin
    #1;
    if (rst_n && imem_req) begin
      if (icnt >= imem_wait) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr]; icnt = 0;
      end else begin
        imem_ack = 1'b0; icnt++;
      end
    end else begin
      imem_ack = 1'b0; icnt = 0;
    end
  end

  // Data memory responder
  always @(posedge clk) begin
    #1;
    if (rst_n && dmem_req) begin
      if (dcnt >= dmem_wait) begin
        dmem_ack = 1'b1; dcnt = 0;
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata; last_st_addr = dmem_addr;
        end else begin
          dmem_rdata = dmem[dmem_addr];
        end
      end else begin
        dmem_ack = 1'b0; dcnt++;
      end
    end else begin
      dmem_ack = 1'b0; dcnt = 0;
    end
  end

  // Monitor: writeback scoreboard, fetch trace and request stability
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_ireq = 1'b0; pv_dreq = 1'b0;
    end else begin
      if (value_valid) begin
        if (exp_val_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected value pulse: got %0h, none expected", value);
        end else begin
          check("wb value", value, exp_val_q.pop_front());
        end
      end
      if (fetch_chk && imem_req && imem_ack && exp_fetch_q.size() > 0)
        check("fetch addr", imem_addr, exp_fetch_q.pop_front());
      if (pv_ireq) begin
        check("imem_req held", imem_req, 1'b1);
        check("imem_addr held", imem_addr, pv_iaddr);
      end
      if (pv_dreq) begin
        check("dmem_req held", dmem_req, 1'b1);
        check("dmem_we held", dmem_we, pv_we);
        check("dmem_addr held", dmem_addr, pv_daddr);
        check("dmem_wdata held", dmem_wdata, pv_wdata);
      end
      pv_ireq = imem_req && !imem_ack; pv_iaddr = imem_addr;
      pv_dreq = dmem_req && !dmem_ack; pv_daddr = dmem_addr;
      pv_we = dmem_we; pv_wdata = dmem_wdata;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'h0; dmem[i] = '0;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic enter_rst();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
    end while (!halted && cyc < 3000);
    check("halted reached", halted, 1'b1);
  endtask

  task automatic drain_fetch();
    int t = 0;
    while (exp_fetch_q.size() > 0 && t < 500) begin
      @(negedge clk); t++;
    end
    check("fetch trace complete", 64'(exp_fetch_q.size()), 64'd0);
  endtask

  initial begin
    int   cyc;
    int   t;
    logic seen;

    // Program 1: addi/addi/add/halt, zero-wait memories
    clear_mem();
    imem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd7);
    imem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("reset imem_req", imem_req, 1'b0);
    check("reset imem_addr", imem_addr, '0);
    check("reset dmem_req", dmem_req, 1'b0);
    check("reset dmem_we", dmem_we, 1'b0);
    check("reset value", value, '0);
    check("reset value_valid", value_valid, 1'b0);
    check("reset halted", halted, 1'b0);
    exp_val_q.push_back(32'd5); exp_val_q.push_back(32'd7); exp_val_q.push_back(32'd12);
    release_rst();
    run_to_halt(cyc);
    check("p1 cycles to halt", 64'(cyc), 64'd15);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk); seen = seen | imem_req | dmem_req;
    end
    check("no req after halt", seen, 1'b0);
    check("halted sticky", halted, 1'b1);
    check("p1 last value", value, 32'd12);
    check("p1 pending values", 64'(exp_val_q.size()), 64'd0);

    // Program 2: store then load with wait states on both memories
    enter_rst();
    clear_mem();
    imem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd7);
    imem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = i_type(6'h2B, 5'd0, 5'd3, 16'd4);
    imem[4] = i_type(6'h23, 5'd0, 5'd4, 16'd4);
    imem[5] = 32'hFFFF_FFFF;
    imem_wait = 2; dmem_wait = 3;
    exp_val_q.push_back(32'd5); exp_val_q.push_back(32'd7);
    exp_val_q.push_back(32'd12); exp_val_q.push_back(32'd12);
    release_rst();
    run_to_halt(cyc);
    check("p2 store addr", last_st_addr, 10'd4);
    check("p2 stored data", dmem[4], 32'd12);
    check("p2 pending values", 64'(exp_val_q.size()), 64'd0);

    // Program 3: branches, wrap, slt, dropped writes, out-of-range register
    enter_rst();
    clear_mem();
    imem[0]  = i_type(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1]  = i_type(6'h08, 5'd0, 5'd2, 16'd2);
    imem[2]  = i_type(6'h04, 5'd1, 5'd2, 16'd3);
    imem[3]  = i_type(6'h08, 5'd0, 5'd5, 16'hFFFF);
    imem[4]  = r_type(5'd5, 5'd5, 5'd6, 6'h20);
    imem[5]  = r_type(5'd5, 5'd0, 5'd7, 6'h2A);
    imem[6]  = i_type(6'h08, 5'd0, 5'd0, 16'd9);
    imem[7]  = i_type(6'h08, 5'd0, 5'd9, 16'd3);
    imem[8]  = r_type(5'd9, 5'd1, 5'd4, 6'h20);
    imem[9]  = i_type(6'h04, 5'd0, 5'd0, 16'd0);
    imem[10] = i_type(6'h04, 5'd1, 5'd1, 16'hFFFF);
    imem_wait = 1; dmem_wait = 0;
    exp_val_q.push_back(32'd1); exp_val_q.push_back(32'd2);
    exp_val_q.push_back(32'hFFFF_FFFF); exp_val_q.push_back(32'hFFFF_FFFE);
    exp_val_q.push_back(32'd1); exp_val_q.push_back(32'd1);
    for (int i = 0; i <= 10; i++) exp_fetch_q.push_back(AW'(i));
    exp_fetch_q.push_back(10'd10); exp_fetch_q.push_back(10'd10);
    fetch_chk = 1'b1;
    release_rst();
    drain_fetch();
    check("p3 pending values", 64'(exp_val_q.size()), 64'd0);

    // Reset while a fetch is waiting for its ack
    t = 0;
    do begin
      @(posedge clk); #2; t++;
    end while (!(imem_req && !imem_ack) && t < 100);
    check("found waiting fetch", imem_req && !imem_ack, 1'b1);
    rst_n = 1'b0;
    #1;
    check("imem_req dropped by reset", imem_req, 1'b0);
    check("pc cleared by reset", imem_addr, '0);
    check("value_valid low in reset", value_valid, 1'b0);

    // Program 4: branch to 0x3FF, NOP there wraps PC to 0
    clear_mem();
    imem[0] = i_type(6'h04, 5'd0, 5'd0, 16'h03FE);
    exp_fetch_q.push_back(10'd0); exp_fetch_q.push_back(10'h3FF); exp_fetch_q.push_back(10'd0);
    repeat (2) @(negedge clk);
    release_rst();
    drain_fetch();
    check("p4 no value pulses", 64'(exp_val_q.size()), 64'd0);

    enter_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle datapath. Executes a MIPS integer subset over an FSM and talks to external instruction and data memories through req/ack handshakes, so it tolerates wait states. Contains its own NREG-entry register file. Exposes a writeback tap (value/value_valid) and a halted flag for the bench and top level.

Parameters:
DATA_W, 32, datapath and register width (>=16)
ADDR_W, 10, word-address width for PC and data memory
NREG, 32, register count; power of two, 2..32

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch word address (= PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  ADDR_W  ALU result [ADDR_W-1:0]
dmem_wdata  out  DATA_W  rt value for stores
dmem_ack  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  DATA_W  load data
value  out  DATA_W  last data written to the register file
value_valid  out  1  one-cycle pulse on each register write
halted  out  1  high once halt instruction executed

Behaviour:
- Reset (async, rst_n=0): PC=0, all registers 0, state=IF, every output 0. Deassertion takes effect at next clk edge.
- States: IF -> ID -> EX -> {MEM | WB | IF} ; MEM -> {WB | IF} ; WB -> IF ; HALT absorbing.
- IF: imem_req=1, imem_addr=PC, held stable until the edge sampling imem_ack=1; then IR latched, go ID.
- ID: read rs=IR[25:21], rt=IR[20:16] into A/B; imm = sign-extend IR[15:0] to DATA_W. IR==32'hFFFF_FFFF -> HALT (halted=1 from next cycle, no req ever again until reset).
- EX: op 0x00 funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), dest rd=IR[15:11] -> WB. addi 0x08: A+imm, dest rt -> WB. lw 0x23 / sw 0x2B: addr=A+imm -> MEM. beq 0x04: if A==B PC=PC+1+imm else PC+1 -> IF. Any other encoding: NOP, PC+1 -> IF.
- Arithmetic wraps modulo 2^DATA_W; PC wraps modulo 2^ADDR_W (0x3FF+1 -> 0 at default).
- MEM: dmem_req=1, dmem_we=1 for sw; addr/wdata/we stable until edge with dmem_ack=1. sw -> IF with PC+1; lw latches dmem_rdata -> WB.
- WB: write dest; PC+1; value<=write data, value_valid=1 for exactly this edge's following cycle; -> IF.
- Register 0 reads 0; writes to reg 0 are dropped and produce no value_valid pulse. Register index >= NREG: read 0, write dropped (no pulse).
- Zero-wait latency (ack high on first req cycle): ALU/addi 4 cycles, lw 5, sw 4, beq/NOP 3.
- imem_ack/dmem_ack outside their request state are ignored. Reset mid-request drops req immediately (combinationally via async reset).

Optional Feature:
MIPS_PERF_CNT_EN: when defined, adds outputs cycle_cnt (32) and retire_cnt (32); cycle_cnt increments every non-reset cycle while not halted, retire_cnt increments on each instruction leaving its final state (including NOP, beq, halt); both reset to 0 and saturate at 32'hFFFF_FFFF. When undefined the ports and counters do not exist; all other behaviour identical.

Test Plan:
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt, zero-wait mems -> value_valid pulses with value 5, 7, 12; halted=1 after 15 cycles; no imem_req afterwards.
- sw $3,4($0) then lw $4,4($0) with dmem_ack delayed 3 cycles -> dmem_addr=4, wdata held 12 through wait, value=12 on lw WB; reqs never drop before ack.
- beq $1,$1,-1 at PC 10 -> next imem_addr=10; beq $1,$2,+3 (unequal) -> next imem_addr=PC+1.
- addi $5,$0,-1 then add $6,$5,$5 -> value 0xFFFF_FFFE (wrap); slt $7,$5,$0 -> 1; addi $0,$0,9 -> no value_valid.
- PC at 0x3FF executing NOP -> next imem_addr=0; NREG=8 build, addi $9,$0,3 -> no pulse, read $9 = 0.
- rst_n pulsed low while imem_req waiting on ack -> imem_req=0 same cycle, PC=0, fetch restarts at 0 after release.
